dmem_access_unit: RTL and testbench

//  Data-memory access sequencer for the single-cycle core; consumes memread/memwrite
//  and funct3 from the ID control path and drives a req/gnt/rvalid data-memory bus.

---
 rtl/dmem_access_unit.sv | 154 +++++++++++++++
 tb/tb_dmem_access_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Data-memory access sequencer: turns a load/store from the single-cycle core into a
// req/gnt/rvalid bus transaction, stalling the core until the access completes.
module dmem_access_unit #(
   parameter int XLEN        = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            memread,
   input  logic            memwrite,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            stall,
   output logic [XLEN-1:0] rdata,
   output logic            misaligned,
   output logic            bus_err,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   output logic [3:0]      bus_be,
   input  logic            bus_gnt,
   input  logic            bus_rvalid,
   input  logic [XLEN-1:0] bus_rdata
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   // Load attributes kept for extending the returned word.
   typedef struct packed {
      logic [2:0] f3;
      logic [1:0] off;
   } acc_t;

   state_t          state;
   acc_t            acc;
   logic [CW-1:0]   cnt;
   logic            access, is_wr, legal_size, legal_op, legal, to_hit;
   logic [XLEN-1:0] st_wdata;
   logic [3:0]      st_be;

   function automatic logic [XLEN-1:0] ld_ext(input logic [XLEN-1:0] w, input acc_t a);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a.off, 3'b000} +: 8];
      h = w[{a.off[1], 4'b0000} +: 16];
      case (a.f3)
         3'b000:  return {{(XLEN-8){b[7]}}, b};
         3'b001:  return {{(XLEN-16){h[15]}}, h};
         3'b100:  return {{(XLEN-8){1'b0}}, b};
         3'b101:  return {{(XLEN-16){1'b0}}, h};
         default: return w;
      endcase
   endfunction

   assign access = memread | memwrite;
   assign is_wr  = memwrite & ~memread;
   assign to_hit = (cnt == CW'(TIMEOUT_CYC - 1));

   always_comb begin
      legal_size = 1'b0;
      st_wdata   = wdata;
      st_be      = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            legal_size = 1'b1;
            st_wdata   = {4{wdata[7:0]}};
            st_be      = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            legal_size = ~addr[0];
            st_wdata   = {2{wdata[15:0]}};
            st_be      = 4'b0011 << {addr[1], 1'b0};
         end
         2'b10:   legal_size = (addr[1:0] == 2'b00);
         default: legal_size = 1'b0;
      endcase
   end

   // Unsigned loads only exist for byte/half; stores have no unsigned forms.
   assign legal_op = is_wr ? ~funct3[2] : (funct3[2:1] != 2'b11);
   assign legal    = legal_size & legal_op;
   assign stall    = ((state == IDLE) & access & legal) | (state == REQ) | (state == RESP);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         acc        <= '0;
         cnt        <= '0;
         rdata      <= '0;
         misaligned <= 1'b0;
         bus_err    <= 1'b0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         bus_be     <= '0;
      end else begin
         misaligned <= 1'b0;
         bus_err    <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (access && legal) begin
                  acc       <= '{f3: funct3, off: addr[1:0]};
                  bus_req   <= 1'b1;
                  bus_we    <= is_wr;
                  bus_addr  <= {addr[XLEN-1:2], 2'b00};
                  bus_wdata <= is_wr ? st_wdata : '0;
                  bus_be    <= is_wr ? st_be : 4'b1111;
                  state     <= REQ;
               end else if (access) begin
                  misaligned <= 1'b1;
               end
            end
            REQ: begin
               cnt <= cnt + 1'b1;
               if (bus_gnt) begin
                  bus_req <= 1'b0;
                  if (bus_we) begin
                     state <= DONE;
                  end else if (bus_rvalid) begin
                     rdata <= ld_ext(bus_rdata, acc);
                     state <= DONE;
                  end else begin
                     state <= RESP;
                  end
               end else if (to_hit) begin
                  bus_err <= 1'b1;
                  bus_req <= 1'b0;
                  rdata   <= '0;
                  state   <= DONE;
               end
            end
            RESP: begin
               cnt <= cnt + 1'b1;
               if (bus_rvalid) begin
                  rdata <= ld_ext(bus_rdata, acc);
                  state <= DONE;
               end else if (to_hit) begin
                  bus_err <= 1'b1;
                  rdata   <= '0;
                  state   <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized scoreboard bench for dmem_access_unit: driver pushes expected bus
// requests and completions; a negedge monitor pops and compares them.
module tb_dmem_access_unit;
   localparam int XLEN = 32;
   localparam int TO   = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            memread, memwrite;
   logic [2:0]      funct3;
   logic [XLEN-1:0] addr, wdata;
   logic            stall, misaligned, bus_err, bus_req, bus_we;
   logic [XLEN-1:0] rdata, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]      bus_be;
   logic            bus_gnt, bus_rvalid;

   always #5 clk = ~clk;

   dmem_access_unit #(.XLEN(XLEN), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite), .funct3(funct3),
      .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .misaligned(misaligned),
      .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata)
   );

   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } req_t;
   typedef struct { logic [31:0] rdata; logic err; int stall_cyc; } done_t;

   req_t        req_q[$];
   done_t       done_q[$];
   int          mis_pending = 0;
   logic [31:0] model_rdata = 32'h0;
   int          n_pass = 0, n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", nm, act, exp, $time);
   endtask

   task automatic fail(input string nm);
      n_total++;
      $display("FAIL %s: unexpected event @%0t", nm, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic bit legal_acc(input bit rd, input logic [2:0] f3, input logic [31:0] a);
      int n;
      n = 1 << f3[1:0];
      if (rd) begin
         if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
      end else if (!(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
      return (a % n) == 0;
   endfunction

   function automatic req_t mk_req(input bit rd, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd);
      req_t        r;
      logic [31:0] w;
      logic [3:0]  be;
      int          n, off;
      r.we   = !rd;
      r.addr = a - (a % 4);
      if (rd) begin
         r.be    = 4'hF;
         r.wdata = 32'h0;
      end else begin
         n   = 1 << f3[1:0];
         off = a % 4;
         w   = 32'h0;
         be  = 4'h0;
         for (int i = 0; i < 4; i++) begin
            be[i]        = (i >= off) && (i < off + n);
            w[8*i +: 8]  = 8'(wd >> (8 * (i % n)));
         end
         r.be    = be;
         r.wdata = w;
      end
      return r;
   endfunction

   function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] word);
      longint v;
      int     n, off;
      n   = 1 << f3[1:0];
      off = a % 4;
      v   = (longint'(word) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
      if (!f3[2] && n < 4 && v >= longint'(64'd1 << (8 * n - 1))) v = v - longint'(64'd1 << (8 * n));
      return 32'(v);
   endfunction

   // ---------------- monitor ----------------
   logic prev_stall = 1'b0, prev_req = 1'b0;
   int   run = 0;

   always @(negedge clk) begin
      req_t  r;
      done_t d;
      if (!rst) begin
         prev_stall = 1'b0;
         prev_req   = 1'b0;
         run        = 0;
      end else begin
         if (stall) run++;
         if (bus_req && !prev_req) begin
            if (req_q.size() == 0) fail("unexpected_bus_req");
            else begin
               r = req_q.pop_front();
               chk("bus_we", bus_we, r.we);
               chk("bus_addr", bus_addr, r.addr);
               chk("bus_wdata", bus_wdata, r.wdata);
               chk("bus_be", bus_be, r.be);
            end
         end
         if (!stall && prev_stall) begin
            if (done_q.size() == 0) fail("unexpected_done");
            else begin
               d = done_q.pop_front();
               chk("done_rdata", rdata, d.rdata);
               chk("done_bus_err", bus_err, d.err);
               chk("stall_cycles", run, d.stall_cyc);
               chk("done_bus_req", bus_req, 1'b0);
            end
            run = 0;
         end else if (bus_err) fail("stray_bus_err");
         if (misaligned) begin
            if (mis_pending == 0) fail("unexpected_misaligned");
            else begin
               mis_pending--;
               chk("mis_stall", stall, 1'b0);
               chk("mis_bus_req", bus_req, 1'b0);
            end
         end
         prev_stall = stall;
         prev_req   = bus_req;
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int gdly, input int rvd,
                      input logic [31:0] rw, input bit never_gnt);
      bit    legal;
      done_t d;
      legal = legal_acc(rd, f3, a);
      if (legal) begin
         req_q.push_back(mk_req(rd, f3, a, wd));
         if (never_gnt) begin
            model_rdata = 32'h0;
            d.err       = 1'b1;
            d.stall_cyc = 1 + TO;
         end else begin
            if (rd) model_rdata = ld_val(f3, a, rw);
            d.err       = 1'b0;
            d.stall_cyc = 1 + gdly + 1 + ((rd && rvd > 0) ? rvd : 0);
         end
         d.rdata = model_rdata;
         done_q.push_back(d);
      end else mis_pending++;

      memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
      tick();
      memread = 1'b0; memwrite = 1'b0; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      if (!legal) begin
         repeat (2) tick();
         return;
      end
      if (never_gnt) begin
         repeat (TO) tick();
      end else begin
         repeat (gdly) tick();
         bus_gnt = 1'b1;
         if (rd && rvd == 0) begin bus_rvalid = 1'b1; bus_rdata = rw; end
         tick();
         bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
         if (rd && rvd > 0) begin
            repeat (rvd - 1) tick();
            bus_rvalid = 1'b1; bus_rdata = rw;
            tick();
            bus_rvalid = 1'b0; bus_rdata = $urandom;
         end
      end
      tick();
   endtask

   // Stray gnt/rvalid while idle must not disturb anything.
   task automatic idle_noise();
      bus_gnt = 1'($urandom); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
      tick();
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      chk("idle_rdata_hold", rdata, model_rdata);
      chk("idle_bus_req", bus_req, 1'b0);
   endtask

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          k;
      bit          rd, wr;
      rst = 1'b0; memread = 1'b0; memwrite = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      repeat (2) tick();
      chk("rst_stall", stall, 1'b0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_misaligned", misaligned, 1'b0);
      chk("rst_bus_err", bus_err, 1'b0);
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_bus_be", bus_be, 4'h0);
      rst = 1'b1;
      tick();

      // Reset while waiting for read data; the late rvalid must be ignored.
      req_q.push_back(mk_req(1, 3'b010, 32'h200, 32'h0));
      memread = 1'b1; funct3 = 3'b010; addr = 32'h200;
      tick();
      memread = 1'b0; bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("midrst_bus_req", bus_req, 1'b0);
      chk("midrst_stall", stall, 1'b0);
      bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
      tick();
      bus_rvalid = 1'b0;
      chk("midrst_rdata", rdata, 32'h0);
      chk("midrst_stall2", stall, 1'b0);
      tick();

      // Directed cases.
      txn(1, 0, 3'b010, 32'h100, 32'h0, 1, 1, 32'hDEADBEEF, 0);
      txn(1, 0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80112233, 0);
      txn(1, 0, 3'b100, 32'h103, 32'h0, 0, 2, 32'h80112233, 0);
      txn(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 0, 0, 32'h0, 0);
      txn(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 0);
      idle_noise();
      txn(1, 0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0, 1);
      txn(1, 1, 3'b010, 32'h040, 32'h55AA55AA, 2, 0, 32'hCAFEF00D, 0);
      txn(1, 0, 3'b110, 32'h040, 32'h0, 0, 0, 32'h0, 0);
      txn(0, 1, 3'b100, 32'h041, 32'h0, 0, 0, 32'h0, 0);
      txn(0, 1, 3'b011, 32'h048, 32'h0, 0, 0, 32'h0, 0);

      // Randomized traffic.
      for (int i = 0; i < 200; i++) begin
         k  = $urandom_range(0, 9);
         rd = (k < 5) || (k == 9);
         wr = (k >= 5);
         if ($urandom_range(0, 9) < 8) begin
            f3 = rd ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 2));
            if (rd && f3 == 3'd3) f3 = 3'd5;
         end else f3 = 3'($urandom);
         a = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) < 7) a = a | ($urandom & ((32'd1 << f3[1:0]) - 1) & 32'h0) | 32'(($urandom_range(0, 3) >> f3[1:0]) << f3[1:0]);
         else a = a | 32'($urandom_range(0, 3));
         txn(rd, wr, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0);
         if ($urandom_range(0, 3) == 0) idle_noise();
      end

      repeat (3) tick();
      chk("req_q_drained", req_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);
      chk("mis_drained", mis_pending, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
